// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit sequencer driving an external 11-bit PISO UART shift register.
// Optional one-entry hold buffer enabled by defining UART_TX_HOLD_EN.
`default_nettype none

module uart_tx_ctrl #(
  parameter int BIT_TIME = 5208,
  parameter int CNT_W    = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_data,
  input  logic        i_eight,
  input  logic        i_pen,
  input  logic        i_ohel,
  output logic        o_ld,
  output logic        o_shift,
  output logic [10:0] o_frame,
  output logic        o_busy,
  output logic        o_tx_done,
  output logic        o_hold_full
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BIT_TIME - 1);
  localparam logic [3:0]       C_LAST_BIT = 4'd10;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bitcnt;
  logic             r_ld;
  logic             r_shift;
  logic             r_busy;
  logic             r_tx_done;
  logic [10:0]      r_frame;

  logic             w_par;
  logic [10:0]      w_frame;
  logic             w_cnt_tc;

`ifdef UART_TX_HOLD_EN
  logic [10:0]      r_hold;
  logic             r_hold_full;
  assign o_hold_full = r_hold_full;
`else
  assign o_hold_full = 1'b0;
`endif

  always_comb begin
    w_par = (i_eight ? ^i_data : ^i_data[6:0]) ^ i_ohel;
    case ({i_eight, i_pen})
      2'b11:   w_frame = {1'b1, w_par, i_data, 1'b0};
      2'b10:   w_frame = {2'b11, i_data, 1'b0};
      2'b01:   w_frame = {2'b11, w_par, i_data[6:0], 1'b0};
      default: w_frame = {3'b111, i_data[6:0], 1'b0};
    endcase
  end

  assign w_cnt_tc = (r_cnt == C_CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bitcnt  <= '0;
      r_ld      <= 1'b0;
      r_shift   <= 1'b0;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
      r_frame   <= 11'h7FF;
`ifdef UART_TX_HOLD_EN
      r_hold      <= 11'h7FF;
      r_hold_full <= 1'b0;
`endif
    end else begin
      r_ld      <= 1'b0;
      r_shift   <= 1'b0;
      r_tx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef UART_TX_HOLD_EN
          // A held frame takes priority and launches straight after tx_done.
          if (r_hold_full) begin
            r_frame     <= r_hold;
            r_hold_full <= 1'b0;
            r_state     <= S_LOAD;
            r_ld        <= 1'b1;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
          end else
`endif
          if (i_start) begin
            r_frame <= w_frame;
            r_state <= S_LOAD;
            r_ld    <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_LOAD, S_SEND: begin
          r_state <= S_SEND;
          if (w_cnt_tc) begin
            r_cnt   <= '0;
            r_shift <= 1'b1;
            if (r_bitcnt == C_LAST_BIT) begin
              r_bitcnt  <= '0;
              r_tx_done <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`ifdef UART_TX_HOLD_EN
          if (i_start && !r_hold_full) begin
            r_hold      <= w_frame;
            r_hold_full <= 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ld      = r_ld;
  assign o_shift   = r_shift;
  assign o_frame   = r_frame;
  assign o_busy    = r_busy;
  assign o_tx_done = r_tx_done;

endmodule

`default_nettype wire
